// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared phase indices, FSM encoding and defaults for the CPU sequencer
package cpu_pkg;

    localparam int FETCH_B = 0;
    localparam int EXEC1_B = 1;
    localparam int EXEC2_B = 2;
    localparam int EXEC3_B = 3;

    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_HALT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC1 = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_EXEC3 = 3'd4
    } fsm_state_t;

    // One-hot phase vector seen by the decoder for a given FSM state; HALT drives all zeros
    function automatic logic [3:0] phase_of(fsm_state_t s);
        logic [3:0] p;
        p = 4'b0000;
        case (s)
            ST_FETCH: p[FETCH_B] = 1'b1;
            ST_EXEC1: p[EXEC1_B] = 1'b1;
            ST_EXEC2: p[EXEC2_B] = 1'b1;
            ST_EXEC3: p[EXEC3_B] = 1'b1;
            default:  p = 4'b0000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/cpu_sequencer_stack_depth_tracker.sv
// rtl/cpu_sequencer_stack_depth_tracker.sv - return-stack occupancy counter with boundary fault detection
module stack_depth_tracker
    import cpu_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] depth,
    output logic       overflow,
    output logic       underflow,
    output logic       collide
);

    localparam logic [3:0] FULL = 4'(STACK_DEPTH);

    logic [3:0] depth_q;
    logic [3:0] depth_d;
    logic       err;

    // Classify the requested stack operation against the current occupancy
    always_comb begin
        overflow  = enable & push & (depth_q == FULL);
        underflow = enable & pop & (depth_q == 4'd0);
        collide   = enable & push & pop;
        err       = overflow | underflow | collide;
    end

    // Next occupancy: clear wins, a faulting operation leaves the depth untouched
    always_comb begin
        depth_d = depth_q;
        if (clear) begin
            depth_d = 4'd0;
        end else if (enable && !err) begin
            if (push) begin
                depth_d = depth_q + 4'd1;
            end else if (pop) begin
                depth_d = depth_q - 4'd1;
            end
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= 4'd0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign depth = depth_q;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - instruction phase sequencer with stack fault tracking and retire counter
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int CNT_W       = 16,
    parameter bit AUTO_START  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             e,
    input  logic             m,
    input  logic             stp,
    input  logic             push,
    input  logic             pop,
    input  logic             mul_done,
    output logic [3:0]       state,
    output logic             mul_start,
    output logic             halted,
    output logic             fault,
    output logic [3:0]       stack_depth,
    output logic [CNT_W-1:0] instr_count
);

    localparam fsm_state_t RESET_STATE = AUTO_START ? ST_FETCH : ST_HALT;

    fsm_state_t       state_q;
    fsm_state_t       state_d;
    logic [3:0]       phase_q;
    logic [3:0]       phase_d;
    logic             halted_q;
    logic             halted_d;
    logic             mul_start_q;
    logic             mul_start_d;
    logic             fault_q;
    logic             fault_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             retire;
    logic             fault_set;
    logic             restart;
    logic             in_exec1;
    logic             stk_over;
    logic             stk_under;
    logic             stk_collide;
    logic             stk_err;

    assign restart  = (state_q == ST_HALT) & start;
    assign in_exec1 = (state_q == ST_EXEC1);
    assign stk_err  = stk_over | stk_under | stk_collide;

    stack_depth_tracker #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .enable   (in_exec1),
        .clear    (restart),
        .depth    (stack_depth),
        .overflow (stk_over),
        .underflow(stk_under),
        .collide  (stk_collide)
    );

    // State register plus the registered outputs that must move together with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            phase_q     <= phase_of(RESET_STATE);
            halted_q    <= (RESET_STATE == ST_HALT);
            mul_start_q <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            halted_q    <= halted_d;
            mul_start_q <= mul_start_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
        end
    end

    // Next-state decision; also flags retirement and stack faults on the transition edge
    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC1;
            end
            ST_EXEC1: begin
                if (stk_err) begin
                    state_d   = ST_HALT;
                    fault_set = 1'b1;
                end else if (stp) begin
                    state_d = ST_HALT;
                    retire  = 1'b1;
                end else if (e) begin
                    state_d = ST_EXEC2;
                end else begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_EXEC2: begin
                if (m) begin
                    state_d = ST_EXEC3;
                end else begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_EXEC3: begin
                if (mul_done) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Phase outputs derived from the upcoming state; mul_start marks only the entry into exec3
    always_comb begin
        phase_d     = phase_of(state_d);
        halted_d    = (state_d == ST_HALT);
        mul_start_d = (state_d == ST_EXEC3) && (state_q != ST_EXEC3);
    end

    // Sticky fault flag and wrapping retire counter
    always_comb begin
        fault_d = fault_q;
        if (restart) begin
            fault_d = 1'b0;
        end
        if (fault_set) begin
            fault_d = 1'b1;
        end
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    assign state       = phase_q;
    assign halted      = halted_q;
    assign mul_start   = mul_start_q;
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized instruction-level model check of cpu_sequencer
module tb_cpu_sequencer;

    localparam int SD = 4;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic          e;
    logic          m;
    logic          stp;
    logic          push;
    logic          pop;
    logic          mul_done;
    logic [3:0]    state;
    logic          mul_start;
    logic          halted;
    logic          fault;
    logic [3:0]    stack_depth;
    logic [CW-1:0] instr_count;

    cpu_sequencer #(
        .STACK_DEPTH(SD),
        .CNT_W      (CW),
        .AUTO_START (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .e          (e),
        .m          (m),
        .stp        (stp),
        .push       (push),
        .pop        (pop),
        .mul_done   (mul_done),
        .state      (state),
        .mul_start  (mul_start),
        .halted     (halted),
        .fault      (fault),
        .stack_depth(stack_depth),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    ph;
        logic          ms;
        logic          flt;
        logic [3:0]    dep;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int            m_depth;
    bit            m_fault;
    bit            m_halted;
    logic [CW-1:0] m_count;

    bit r_e, r_m, r_s, r_pu, r_po;
    int r_k, r_sel;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle that has a modelled expectation is checked at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("state", 16'(state), 16'(x.ph));
            chk("halted", 16'(halted), 16'(x.ph == 4'b0000));
            chk("mul_start", 16'(mul_start), 16'(x.ms));
            chk("fault", 16'(fault), 16'(x.flt));
            chk("stack_depth", 16'(stack_depth), 16'(x.dep));
            chk("instr_count", 16'(instr_count), 16'(x.cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input logic [3:0] ph, input logic ms);
        exp_t x;
        x.ph  = ph;
        x.ms  = ms;
        x.flt = m_fault;
        x.dep = 4'(m_depth);
        x.cnt = m_count;
        exp_q.push_back(x);
    endtask

    task automatic junk(input bit allow_start);
        e        = 1'($urandom_range(0, 1));
        m        = 1'($urandom_range(0, 1));
        stp      = 1'($urandom_range(0, 1));
        push     = 1'($urandom_range(0, 1));
        pop      = 1'($urandom_range(0, 1));
        mul_done = 1'($urandom_range(0, 1));
        start    = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic do_reset(input int n);
        junk(1'b1);
        reset = 1'b1;
        tick();
        m_count = '0;
        m_fault = 1'b0;
        m_depth = 0;
        repeat (n - 1) begin
            expect_now(4'b0001, 1'b0);
            junk(1'b1);
            tick();
        end
        reset = 1'b0;
    endtask

    // One instruction from its fetch cycle to retirement, halt or abort
    task automatic run_instr(input bit ie, input bit im, input bit istp, input bit ipu,
                             input bit ipo, input int k, input bit abort);
        bit flt;
        m_halted = 1'b0;
        expect_now(4'b0001, 1'b0);
        junk(1'b1);
        tick();
        expect_now(4'b0010, 1'b0);
        junk(1'b1);
        e    = ie;
        stp  = istp;
        push = ipu;
        pop  = ipo;
        tick();
        flt = (ipu && ipo) || (ipu && m_depth == SD) || (ipo && m_depth == 0);
        if (flt) begin
            m_fault  = 1'b1;
            m_halted = 1'b1;
            return;
        end
        m_depth = m_depth + int'(ipu) - int'(ipo);
        if (istp) begin
            m_count  = m_count + 1'b1;
            m_halted = 1'b1;
            return;
        end
        if (!ie) begin
            m_count = m_count + 1'b1;
            return;
        end
        expect_now(4'b0100, 1'b0);
        junk(1'b1);
        m = im;
        tick();
        if (!im) begin
            m_count = m_count + 1'b1;
            return;
        end
        for (int j = 1; j <= k; j++) begin
            expect_now(4'b1000, j == 1);
            junk(1'b1);
            mul_done = (j == k) && !abort;
            tick();
            if (abort && j == 2) return;
        end
        m_count = m_count + 1'b1;
    endtask

    task automatic halt_run(input int idle);
        repeat (idle) begin
            expect_now(4'b0000, 1'b0);
            junk(1'b0);
            tick();
        end
        expect_now(4'b0000, 1'b0);
        junk(1'b0);
        start = 1'b1;
        tick();
        start   = 1'b0;
        m_fault = 1'b0;
        m_depth = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; e = 1'b0; m = 1'b0; stp = 1'b0;
        push = 1'b0; pop = 1'b0; mul_done = 1'b0;
        m_depth = 0; m_fault = 1'b0; m_halted = 1'b0; m_count = '0;

        do_reset(2);
        chk("reset_state", 16'(state), 16'h1);
        chk("reset_count", 16'(instr_count), 16'h0);

        repeat (3) run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        chk("plain_count3", 16'(instr_count), 16'h3);

        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        run_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        chk("stp_halted", 16'(halted), 16'h1);
        chk("stp_count", 16'(instr_count), 16'h6);
        halt_run(2);

        repeat (4) run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        chk("depth_full", 16'(stack_depth), 16'h4);
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        chk("ovf_fault", 16'(fault), 16'h1);
        chk("ovf_state", 16'(state), 16'h0);
        chk("ovf_depth", 16'(stack_depth), 16'h4);
        chk("ovf_count", 16'(instr_count), 16'ha);
        halt_run(1);
        chk("start_fault", 16'(fault), 16'h0);
        chk("start_depth", 16'(stack_depth), 16'h0);

        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        chk("udf_fault", 16'(fault), 16'h1);
        halt_run(0);

        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        chk("both_fault", 16'(fault), 16'h1);
        chk("both_depth", 16'(stack_depth), 16'h2);
        halt_run(0);

        for (int i = 0; i < 300; i++) begin
            r_e   = 1'($urandom_range(0, 1));
            r_m   = 1'($urandom_range(0, 1));
            r_s   = ($urandom_range(0, 15) == 0);
            r_sel = $urandom_range(0, 7);
            r_pu  = (r_sel < 2) || (r_sel == 7);
            r_po  = (r_sel == 2) || (r_sel == 3) || (r_sel == 7);
            r_k   = $urandom_range(1, 4);
            run_instr(r_e, r_m, r_s, r_pu, r_po, r_k, 1'b0);
            if (m_halted) halt_run($urandom_range(0, 2));
        end

        run_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        do_reset(1);
        chk("x3rst_state", 16'(state), 16'h1);
        chk("x3rst_mul_start", 16'(mul_start), 16'h0);
        chk("x3rst_count", 16'(instr_count), 16'h0);
        run_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        chk("final_count", 16'(instr_count), 16'h2);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Generates the one-hot phase vector (fetch/exec1/exec2/exec3) that drives the instruction decoder and datapath of the Harvard-architecture CPU.
- Stretches each instruction to the right number of phases from the decoder's e/m flags.
- Halts on stp and waits on the multiplier handshake in exec3.
- Tracks return-stack depth from push/pop, faults on over/underflow, and counts retired instructions.

Parameters:
- STACK_DEPTH, 4, number of return-stack entries (1..15).
- CNT_W, 16, width of retired-instruction counter.
- AUTO_START, 1, 1 = leave reset into FETCH; 0 = leave reset into HALT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves HALT and clears fault.
- e  in  1  decoder: instruction needs exec2.
- m  in  1  decoder: instruction needs exec3 (multiply).
- stp  in  1  decoder: current instruction is stop.
- push  in  1  decoder: return-stack push (valid in exec1).
- pop  in  1  decoder: return-stack pop (valid in exec1).
- mul_done  in  1  multiplier result ready.
- state  out  4  one-hot phase: [0]=fetch, [1]=exec1, [2]=exec2, [3]=exec3; 0000 in HALT.
- mul_start  out  1  one-cycle pulse on entry to exec3.
- halted  out  1  high while in HALT.
- fault  out  1  sticky stack over/underflow flag.
- stack_depth  out  4  current return-stack occupancy.
- instr_count  out  CNT_W  retired instructions, wraps.

Behaviour:
- Reset, synchronous, active-high, has priority over everything:
  - AUTO_START=1: state=0001, halted=0.
  - AUTO_START=0: state=0000, halted=1.
  - fault=0, stack_depth=0, instr_count=0, mul_start=0.
  - Reset mid-instruction (including exec3 waiting on mul_done) aborts with no count increment.
- FSM states HALT, FETCH, EXEC1, EXEC2, EXEC3; registered one-hot outputs; exactly one state bit set outside HALT.
- HALT: stays until start=1, then FETCH next cycle. start also clears fault and resets stack_depth to 0. start is ignored outside HALT.
- FETCH -> EXEC1 unconditionally, one cycle.
- EXEC1, priority order:
  1. Stack fault: push while stack_depth==STACK_DEPTH, or pop while stack_depth==0, or push&pop together -> HALT, fault=1, depth unchanged, no retire.
  2. stp -> HALT, retire.
  3. e -> EXEC2.
  4. Otherwise -> FETCH, retire.
- EXEC1 depth update (non-fault only): push -> depth+1; pop -> depth-1. Updates in the same cycle as the transition. push/pop outside EXEC1 are ignored.
- EXEC2: m -> EXEC3 with mul_start=1 in the first EXEC3 cycle; else -> FETCH, retire.
- EXEC3: holds while mul_done=0, with no timeout and mul_start low after the first cycle. mul_done=1 -> FETCH, retire. If mul_done is already high in the first EXEC3 cycle, exec3 lasts one cycle.
- Retire means instr_count increments by 1 on the transition clock edge, modulo 2^CNT_W (0xFFFF -> 0x0000).
- Latency per instruction:
  - 2 cycles without e.
  - 3 cycles with e and no m.
  - 3 + k cycles with m, where k = cycles until mul_done is sampled high, minimum 1.
- e/m/stp are sampled only in the phase where they are used; values in other phases are don't-care.
- halted = (state==0000), registered together with state.

Decomposition:
- Shared package cpu_pkg:
  - Phase bit indices FETCH_B=0, EXEC1_B=1, EXEC2_B=2, EXEC3_B=3.
  - 3-bit FSM state encoding constants for HALT/FETCH/EXEC1/EXEC2/EXEC3.
  - STACK_DEPTH default.
- One natural sub-module: stack_depth_tracker. Inputs: push, pop, enable, clear. Outputs: depth, over/underflow. It keeps the boundary logic separately testable. The FSM and retire counter stay in cpu_sequencer.

Test Plan:
- AUTO_START=1, reset high 2 cycles then low; e=0, stp=0 -> state sequence 0001, 0010, 0001, 0010…; instr_count increments every 2 cycles, reaching 3 after 6 cycles.
- lda-like instruction (e=1, m=0) -> 0001, 0010, 0100, 0001; one retire. Multiply (e=1, m=1) with mul_done raised 3 cycles after exec3 entry -> exec3 held 4 cycles, mul_start high for exactly 1 cycle, one retire.
- stp=1 in EXEC1 -> state=0000, halted=1, instr_count+1. Extra start pulses in HALT beyond the first are ignored. start pulse -> FETCH next cycle.
- Five consecutive pushes with STACK_DEPTH=4 -> depth 1,2,3,4; fifth push -> fault=1, HALT, depth stays 4, no retire. start -> fault=0, depth=0.
- pop at depth 0 -> fault=1, HALT. Push and pop together at depth 2 -> fault, depth stays 2.
- Preload near wrap: run with CNT_W=4 for 16 retires -> instr_count goes 15 -> 0. Reset asserted during EXEC3 wait -> next cycle matches AUTO_START reset values, mul_start=0.
